countdown_timer_5bit: RTL and testbench



---
 rtl/timer_defs_pkg.sv | 17 +
 rtl/countdown_timer_5bit_tick_gen.sv | 31 +++
 rtl/countdown_timer_5bit.sv | 109 ++++++++++
 tb/tb_countdown_timer_5bit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_defs_pkg.sv
// Shared definitions for the lab timer display path: state encoding, count
// direction and the count width shared with the binary-to-decimal converter.
package timer_defs_pkg;

  localparam int COUNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/countdown_timer_5bit_tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and pulses tick on the
// cycle it wraps back to 0. Clear has priority over enable.
module tick_gen #(
  parameter int unsigned PRESCALE = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(PRESCALE - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_5bit.sv
// Start/pause/resume timer with load and up/down direction; the count feeds
// the binary-to-decimal converter and done flags the terminal value.
module countdown_timer_5bit
  import timer_defs_pkg::*;
#(
  parameter int unsigned PRESCALE   = 100000000,
  parameter int unsigned MAX_COUNT  = 30,
  parameter int unsigned INIT_COUNT = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_stop,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               done,
  output logic               sec_tick
);

  localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] INIT_C = COUNT_W'(INIT_COUNT);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;
  logic               pre_en, pre_clr, wrap, step;

  function automatic logic [COUNT_W-1:0] terminal(input logic d);
    return (d == DIR_UP) ? MAX_C : '0;
  endfunction

  // A load freezes the prescaler so a coincident wrap never produces a step.
  assign pre_en = (state_q == S_RUN) && !load;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (wrap)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    pre_clr = 1'b0;
    step    = 1'b0;

    if (load) begin
      state_d = S_IDLE;
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
      pre_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_stop) begin
            dir_d   = dir;
            pre_clr = 1'b1;
            state_d = (count_q == terminal(dir)) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (start_stop) state_d = S_PAUSE;
          if (wrap && (count_q != terminal(dir_q))) begin
            step    = 1'b1;
            count_d = (dir_q == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
            if (count_d == terminal(dir_q)) state_d = S_DONE;
          end
        end
        S_PAUSE: begin
          if (start_stop) state_d = S_RUN;
        end
        S_DONE: begin
          if (start_stop) begin
            dir_d   = dir;
            count_d = (dir == DIR_UP) ? '0 : INIT_C;
            pre_clr = 1'b1;
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= INIT_C;
      dir_q    <= DIR_DOWN;
      sec_tick <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      sec_tick <= step;
    end
  end

  assign count   = count_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_countdown_timer_5bit.sv
// Self-checking bench: directed scenarios plus random pulses, every cycle
// compared against a cycle-counting behavioural model of the timer.
module tb_countdown_timer_5bit;

  localparam int PRE   = 4;
  localparam int MAXC  = 30;
  localparam int INITC = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_value = '0;
  logic       dir = 1'b0;
  logic [4:0] count;
  logic       running, done, sec_tick;

  int passed = 0;
  int total  = 0;

  // Behavioural model: mode flags, elapsed cycles in the current second.
  int m_count;
  bit m_run, m_pause, m_done, m_up, m_tick;
  int m_elapsed;

  countdown_timer_5bit #(
    .PRESCALE   (PRE),
    .MAX_COUNT  (MAXC),
    .INIT_COUNT (INITC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .load       (load),
    .load_value (load_value),
    .dir        (dir),
    .count      (count),
    .running    (running),
    .done       (done),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int term_of(input bit up);
    return up ? MAXC : 0;
  endfunction

  task automatic model_reset();
    m_count = INITC; m_run = 0; m_pause = 0; m_done = 0;
    m_up = 0; m_tick = 0; m_elapsed = 0;
  endtask

  task automatic model_step(input bit ss, input bit ld, input int lv, input bit d);
    m_tick = 0;
    if (ld) begin
      m_count = (lv > MAXC) ? MAXC : lv;
      m_run = 0; m_pause = 0; m_done = 0; m_elapsed = 0;
    end else if (m_run) begin
      m_elapsed = m_elapsed + 1;
      if (ss) begin m_run = 0; m_pause = 1; end
      if (m_elapsed == PRE) begin
        m_elapsed = 0;
        m_count = m_up ? m_count + 1 : m_count - 1;
        m_tick = 1;
        if (m_count == term_of(m_up)) begin m_run = 0; m_pause = 0; m_done = 1; end
      end
    end else if (m_pause) begin
      if (ss) begin m_pause = 0; m_run = 1; end
    end else if (m_done) begin
      if (ss) begin
        m_up = d; m_count = d ? 0 : INITC; m_elapsed = 0;
        m_done = 0; m_run = 1;
      end
    end else if (ss) begin
      m_up = d; m_elapsed = 0;
      if (m_count == term_of(d)) m_done = 1;
      else m_run = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(start_stop, load, int'(load_value), dir);
    #1;
    check("model_count", 32'(count), 32'(m_count));
    check("model_running", 32'(running), 32'(m_run));
    check("model_done", 32'(done), 32'(m_done));
    check("model_sec_tick", 32'(sec_tick), 32'(m_tick));
    start_stop = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    int ticks;
    model_reset();

    // Reset state
    #12;
    check("reset_count", 32'(count), 32'd30);
    check("reset_running", 32'(running), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sec_tick", 32'(sec_tick), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Count down 30 -> 0
    dir = 1'b0; start_stop = 1'b1; cycle();
    check("start_running", 32'(running), 32'd1);
    ticks = 0;
    for (int i = 1; i <= 120; i++) begin
      cycle();
      ticks += int'(sec_tick);
      if (i == 3) check("pre_first_step", 32'(count), 32'd30);
      if (i == 4) begin
        check("first_step_count", 32'(count), 32'd29);
        check("first_step_tick", 32'(sec_tick), 32'd1);
      end
    end
    check("down_final_count", 32'(count), 32'd0);
    check("down_done", 32'(done), 32'd1);
    check("down_running", 32'(running), 32'd0);
    check("down_tick_total", 32'(ticks), 32'd30);

    // Restart from DONE, then pause 2 cycles after a step
    start_stop = 1'b1; cycle();
    check("restart_count", 32'(count), 32'd30);
    repeat (4) cycle();
    check("restart_step", 32'(count), 32'd29);
    cycle();
    start_stop = 1'b1; cycle();
    check("paused_running", 32'(running), 32'd0);
    repeat (20) cycle();
    check("paused_frozen", 32'(count), 32'd29);
    start_stop = 1'b1; cycle();
    check("resume_running", 32'(running), 32'd1);
    cycle();
    check("resume_no_step_yet", 32'(count), 32'd29);
    cycle();
    check("resume_step_count", 32'(count), 32'd28);
    check("resume_step_tick", 32'(sec_tick), 32'd1);

    // Clamped load, then start at terminal goes straight to DONE
    load = 1'b1; load_value = 5'd31; cycle();
    check("load_clamp", 32'(count), 32'd30);
    check("load_idle", 32'(running), 32'd0);
    load = 1'b1; load_value = 5'd0; cycle();
    dir = 1'b0; start_stop = 1'b1; cycle();
    ticks = int'(sec_tick);
    cycle();
    ticks += int'(sec_tick);
    check("terminal_start_done", 32'(done), 32'd1);
    check("terminal_start_no_tick", 32'(ticks), 32'd0);
    check("terminal_start_count", 32'(count), 32'd0);

    // Count up from 27; dir toggling mid-run is ignored
    dir = 1'b1; load = 1'b1; load_value = 5'd27; cycle();
    start_stop = 1'b1; cycle();
    for (int i = 1; i <= 12; i++) begin
      dir = ~dir;
      cycle();
      if (i == 4)  check("up_28", 32'(count), 32'd28);
      if (i == 8)  check("up_29", 32'(count), 32'd29);
    end
    check("up_30", 32'(count), 32'd30);
    check("up_done", 32'(done), 32'd1);
    repeat (5) cycle();
    check("up_hold", 32'(count), 32'd30);

    // load + start_stop coincident with a prescaler wrap
    dir = 1'b0; start_stop = 1'b1; cycle();
    repeat (3) cycle();
    load = 1'b1; load_value = 5'd12; start_stop = 1'b1; cycle();
    check("wrap_load_count", 32'(count), 32'd12);
    check("wrap_load_idle", 32'(running), 32'd0);
    check("wrap_load_no_tick", 32'(sec_tick), 32'd0);

    // Asynchronous reset mid-RUN
    start_stop = 1'b1; cycle();
    repeat (5) cycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd30);
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      start_stop = ($urandom_range(7) == 0);
      load       = ($urandom_range(39) == 0);
      load_value = 5'($urandom_range(31));
      dir        = 1'($urandom_range(1));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
